// File: rtl/frame_layer_scheduler_if.sv
// Bundle between the timing/game side and the sprite demux side of the layer scheduler.
// master drives pixels, layer enables, FSM requests and the fetched pixel; slave is the scheduler.
interface frame_layer_scheduler_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        frame_start;
    logic        power_on;
    logic [3:0]  btn_lit;
    logic        win_pulse;
    logic        lose_pulse;
    logic        clear;
    logic [2:0]  selector;
    logic [15:0] mem_addr;
    logic [15:0] mem_px;
    logic [15:0] px_out;
    logic        px_valid;
    logic        end_active;
    logic        end_done;

    modport master (
        output pixel_x, pixel_y, pixel_valid, frame_start, power_on, btn_lit,
               win_pulse, lose_pulse, clear, mem_px,
        input  selector, mem_addr, px_out, px_valid, end_active, end_done
    );

    modport slave (
        input  pixel_x, pixel_y, pixel_valid, frame_start, power_on, btn_lit,
               win_pulse, lose_pulse, clear, mem_px,
        output selector, mem_addr, px_out, px_valid, end_active, end_done
    );
endinterface

// File: rtl/frame_layer_scheduler.sv
// Per-pixel sprite layer picker: hit test, priority select, demux address, ROM-aligned output,
// plus the frame-synchronous win/lose end-screen state machine.
module frame_layer_scheduler #(
    parameter int ROM_LAT     = 1,
    parameter int HOLD_FRAMES = 120,
    parameter int BG_X0   = 140, parameter int BG_Y0   = 150,
    parameter int PWR_X0  = 311, parameter int PWR_Y0  = 80,
    parameter int RED_X0  = 226, parameter int RED_Y0  = 156,
    parameter int GRN_X0  = 330, parameter int GRN_Y0  = 156,
    parameter int BLU_X0  = 226, parameter int BLU_Y0  = 323,
    parameter int YEL_X0  = 330, parameter int YEL_Y0  = 323,
    parameter int WIN_X0  = 230, parameter int WIN_Y0  = 182,
    parameter int LOSE_X0 = 230, parameter int LOSE_Y0 = 173
) (
    input logic clk,
    input logic rst_n,
    frame_layer_scheduler_if.slave bus
);
    localparam int NL = 8;
    localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

    // Table index equals the demux selector code.
    localparam logic [NL-1:0][9:0] X0_TAB = {10'(LOSE_X0), 10'(WIN_X0), 10'(YEL_X0), 10'(BLU_X0),
                                             10'(GRN_X0), 10'(RED_X0), 10'(PWR_X0), 10'(BG_X0)};
    localparam logic [NL-1:0][9:0] Y0_TAB = {10'(LOSE_Y0), 10'(WIN_Y0), 10'(YEL_Y0), 10'(BLU_Y0),
                                             10'(GRN_Y0), 10'(RED_Y0), 10'(PWR_Y0), 10'(BG_Y0)};
    localparam logic [NL-1:0][9:0] W_TAB  = {10'd180, 10'd180, 10'd84, 10'd84,
                                             10'd84, 10'd84, 10'd18, 10'd360};
    localparam logic [NL-1:0][9:0] H_TAB  = {10'd134, 10'd116, 10'd166, 10'd167,
                                             10'd167, 10'd167, 10'd14, 10'd180};

    typedef enum logic [2:0] {IDLE, PEND_WIN, PEND_LOSE, SHOW_WIN, SHOW_LOSE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   frame_cnt_reg;
    logic            clear_reg;
    logic            end_active_reg;
    logic            end_done_reg;

    logic [NL-1:0]   layer_en;
    logic [NL-1:0]   s1_hit;
    logic [15:0]     layer_addr [NL];
    logic            s1_valid_reg;

    logic [2:0]      sel_next;
    logic            blank_next;
    logic [2:0]      selector_reg;
    logic [15:0]     mem_addr_reg;
    logic            s2_valid_reg;
    logic            s2_blank_reg;

    logic [ROM_LAT-1:0] dly_valid_reg;
    logic [ROM_LAT-1:0] dly_blank_reg;
    logic [15:0]     px_out_reg;
    logic            px_valid_reg;

    logic            clear_any;

    always_comb begin
        layer_en      = '0;
        layer_en[0]   = 1'b1;
        layer_en[1]   = bus.power_on;
        layer_en[5:2] = bus.btn_lit;
        layer_en[6]   = (state_reg == SHOW_WIN);
        layer_en[7]   = (state_reg == SHOW_LOSE);
    end

    // Stage 1: per-layer gated hit flag and sprite-relative coordinates.
    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_layer
            localparam logic [10:0] X_END = {1'b0, X0_TAB[gi]} + {1'b0, W_TAB[gi]};
            localparam logic [10:0] Y_END = {1'b0, Y0_TAB[gi]} + {1'b0, H_TAB[gi]};
            logic       hit_geo;
            logic       hit_reg;
            logic [9:0] rx_reg;
            logic [9:0] ry_reg;

            assign hit_geo = (bus.pixel_x >= X0_TAB[gi]) && ({1'b0, bus.pixel_x} < X_END) &&
                             (bus.pixel_y >= Y0_TAB[gi]) && ({1'b0, bus.pixel_y} < Y_END);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hit_reg <= 1'b0;
                    rx_reg  <= '0;
                    ry_reg  <= '0;
                end else begin
                    hit_reg <= hit_geo & layer_en[gi];
                    rx_reg  <= bus.pixel_x - X0_TAB[gi];
                    ry_reg  <= bus.pixel_y - Y0_TAB[gi];
                end
            end

            assign s1_hit[gi]     = hit_reg;
            assign layer_addr[gi] = ({6'd0, ry_reg} * {6'd0, W_TAB[gi]}) + {6'd0, rx_reg};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_valid_reg <= 1'b0;
        else        s1_valid_reg <= bus.pixel_valid;
    end

    // Priority: lose, win, power, red, green, blue, yellow, background.
    always_comb begin
        sel_next   = 3'd0;
        blank_next = 1'b0;
        if      (s1_hit[7]) sel_next = 3'd7;
        else if (s1_hit[6]) sel_next = 3'd6;
        else if (s1_hit[1]) sel_next = 3'd1;
        else if (s1_hit[2]) sel_next = 3'd2;
        else if (s1_hit[3]) sel_next = 3'd3;
        else if (s1_hit[4]) sel_next = 3'd4;
        else if (s1_hit[5]) sel_next = 3'd5;
        else if (s1_hit[0]) sel_next = 3'd0;
        else                blank_next = 1'b1;
    end

    // Stage 2: selector/address only move on valid pixels so idle ROM clocks stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selector_reg <= 3'd0;
            mem_addr_reg <= '0;
            s2_valid_reg <= 1'b0;
            s2_blank_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                selector_reg <= sel_next;
                mem_addr_reg <= blank_next ? 16'd0 : layer_addr[sel_next];
                s2_blank_reg <= blank_next;
            end
        end
    end

    // Flags ride alongside the ROM read so output latency is fixed for every layer.
    generate
        for (gi = 0; gi < ROM_LAT; gi++) begin : g_dly
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_valid_reg[gi] <= 1'b0;
                    dly_blank_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    dly_valid_reg[gi] <= s2_valid_reg;
                    dly_blank_reg[gi] <= s2_blank_reg;
                end else begin
                    dly_valid_reg[gi] <= dly_valid_reg[(gi > 0) ? gi - 1 : 0];
                    dly_blank_reg[gi] <= dly_blank_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_out_reg   <= '0;
            px_valid_reg <= 1'b0;
        end else begin
            px_valid_reg <= dly_valid_reg[ROM_LAT-1];
            px_out_reg   <= (dly_valid_reg[ROM_LAT-1] && !dly_blank_reg[ROM_LAT-1]) ? bus.mem_px : 16'd0;
        end
    end

    assign clear_any = clear_reg | bus.clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            frame_cnt_reg  <= '0;
            clear_reg      <= 1'b0;
            end_active_reg <= 1'b0;
            end_done_reg   <= 1'b0;
        end else begin
            end_done_reg <= 1'b0;
            if (state_reg != IDLE && bus.clear) clear_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (bus.lose_pulse)     state_reg <= PEND_LOSE;
                    else if (bus.win_pulse) state_reg <= PEND_WIN;
                end
                PEND_WIN, PEND_LOSE: begin
                    if (state_reg == PEND_WIN && bus.lose_pulse) begin
                        state_reg <= PEND_LOSE;
                    end else if (bus.frame_start) begin
                        if (clear_any) begin
                            state_reg <= IDLE;
                            clear_reg <= 1'b0;
                        end else begin
                            state_reg      <= (state_reg == PEND_WIN) ? SHOW_WIN : SHOW_LOSE;
                            frame_cnt_reg  <= '0;
                            end_active_reg <= 1'b1;
                        end
                    end
                end
                SHOW_WIN, SHOW_LOSE: begin
                    if (state_reg == SHOW_WIN && bus.lose_pulse) begin
                        state_reg      <= PEND_LOSE;
                        end_active_reg <= 1'b0;
                    end else if (bus.frame_start) begin
                        if (clear_any) begin
                            state_reg      <= IDLE;
                            clear_reg      <= 1'b0;
                            end_active_reg <= 1'b0;
                        end else if (frame_cnt_reg == HOLD_LAST) begin
                            state_reg      <= IDLE;
                            end_active_reg <= 1'b0;
                            end_done_reg   <= 1'b1;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    end_active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.selector   = selector_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.px_out     = px_out_reg;
    assign bus.px_valid   = px_valid_reg;
    assign bus.end_active = end_active_reg;
    assign bus.end_done   = end_done_reg;
endmodule

// File: tb/tb_frame_layer_scheduler.sv
// Directed bench for frame_layer_scheduler: hand-computed layer hits, addresses, pipeline timing
// and end-screen sequencing, with a one-cycle sprite ROM model.
module tb_frame_layer_scheduler;
    localparam int ROM_LAT = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] rom_q;

    frame_layer_scheduler_if bus();

    frame_layer_scheduler #(.ROM_LAT(ROM_LAT), .HOLD_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM stand-in: content is a fixed function of selector and address.
    always_ff @(posedge clk) rom_q <= bus.mem_addr ^ {bus.selector, 13'd0};
    assign bus.mem_px = rom_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_px(input string tag, input logic [9:0] x, input logic [9:0] y, input logic v,
                          input logic [2:0] es, input logic [15:0] ea, input logic blank);
        logic [15:0] epx;
        epx = (v && !blank) ? (ea ^ {es, 13'd0}) : 16'd0;
        bus.pixel_x     = x;
        bus.pixel_y     = y;
        bus.pixel_valid = v;
        tick();
        bus.pixel_valid = 1'b0;
        tick();
        check_eq({tag, "_sel"}, 32'(bus.selector), 32'(es));
        check_eq({tag, "_addr"}, 32'(bus.mem_addr), 32'(ea));
        repeat (ROM_LAT + 1) @(posedge clk);
        #1;
        check_eq({tag, "_px"}, 32'(bus.px_out), 32'(epx));
        check_eq({tag, "_pv"}, 32'(bus.px_valid), 32'(v));
        $display("pixel %s (%0d,%0d) v=%0d sel=%0d addr=%0d px=%0h pv=%0d",
                 tag, x, y, v, bus.selector, bus.mem_addr, bus.px_out, bus.px_valid);
    endtask

    task automatic frame_start_pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.pixel_x = '0;  bus.pixel_y = '0;  bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;  bus.power_on = 1'b0;  bus.btn_lit = 4'd0;
        bus.win_pulse = 1'b0;  bus.lose_pulse = 1'b0;  bus.clear = 1'b0;
        repeat (3) tick();
        check_eq("rst_sel", 32'(bus.selector), 0);
        check_eq("rst_addr", 32'(bus.mem_addr), 0);
        check_eq("rst_px", 32'(bus.px_out), 0);
        check_eq("rst_pv", 32'(bus.px_valid), 0);
        check_eq("rst_active", 32'(bus.end_active), 0);
        check_eq("rst_done", 32'(bus.end_done), 0);
        rst_n = 1'b1;
        tick();

        run_px("bg_200", 10'd200, 10'd200, 1'b1, 3'd0, 16'd18060, 1'b0);
        bus.btn_lit = 4'b0001;
        run_px("red_tl", 10'd226, 10'd156, 1'b1, 3'd2, 16'd0, 1'b0);
        run_px("red_br", 10'd309, 10'd322, 1'b1, 3'd2, 16'd14027, 1'b0);
        bus.btn_lit = 4'b0000;
        run_px("red_off", 10'd226, 10'd156, 1'b1, 3'd0, 16'd2246, 1'b0);
        bus.btn_lit = 4'b0010;
        run_px("grn_tl", 10'd330, 10'd156, 1'b1, 3'd3, 16'd0, 1'b0);
        bus.btn_lit = 4'b1000;
        run_px("yel_br", 10'd413, 10'd488, 1'b1, 3'd5, 16'd13943, 1'b0);
        run_px("yel_out", 10'd413, 10'd489, 1'b1, 3'd0, 16'd0, 1'b1);
        bus.btn_lit = 4'b0000;
        bus.power_on = 1'b1;
        run_px("pwr_tl", 10'd311, 10'd80, 1'b1, 3'd1, 16'd0, 1'b0);
        run_px("pwr_br", 10'd328, 10'd93, 1'b1, 3'd1, 16'd251, 1'b0);
        run_px("pwr_out", 10'd329, 10'd93, 1'b1, 3'd0, 16'd0, 1'b1);
        bus.power_on = 1'b0;
        run_px("blank", 10'd0, 10'd0, 1'b1, 3'd0, 16'd0, 1'b1);
        bus.btn_lit = 4'b0001;
        run_px("red_br2", 10'd309, 10'd322, 1'b1, 3'd2, 16'd14027, 1'b0);
        run_px("invalid", 10'd0, 10'd0, 1'b0, 3'd2, 16'd14027, 1'b0);
        bus.btn_lit = 4'b0000;

        // Win screen held for two frames.
        bus.win_pulse = 1'b1;
        tick();
        bus.win_pulse = 1'b0;
        check_eq("win_pend_active", 32'(bus.end_active), 0);
        run_px("win_pre", 10'd230, 10'd182, 1'b1, 3'd0, 16'd11610, 1'b0);
        frame_start_pulse();
        check_eq("win_show_active", 32'(bus.end_active), 1);
        run_px("win_tl", 10'd230, 10'd182, 1'b1, 3'd6, 16'd0, 1'b0);
        run_px("win_br", 10'd409, 10'd297, 1'b1, 3'd6, 16'd20879, 1'b0);
        frame_start_pulse();
        check_eq("win_f1_done", 32'(bus.end_done), 0);
        check_eq("win_f1_active", 32'(bus.end_active), 1);
        frame_start_pulse();
        check_eq("win_f2_done", 32'(bus.end_done), 1);
        check_eq("win_f2_active", 32'(bus.end_active), 0);
        tick();
        check_eq("win_done_pulse", 32'(bus.end_done), 0);
        $display("win hold sequence complete");
        run_px("win_gone", 10'd230, 10'd182, 1'b1, 3'd0, 16'd11610, 1'b0);

        // Lose preempts a showing win.
        bus.win_pulse = 1'b1;
        tick();
        bus.win_pulse = 1'b0;
        frame_start_pulse();
        check_eq("pre_win_active", 32'(bus.end_active), 1);
        bus.lose_pulse = 1'b1;
        tick();
        bus.lose_pulse = 1'b0;
        check_eq("pre_pend_active", 32'(bus.end_active), 0);
        frame_start_pulse();
        check_eq("pre_lose_active", 32'(bus.end_active), 1);
        run_px("lose_tl", 10'd230, 10'd173, 1'b1, 3'd7, 16'd0, 1'b0);
        run_px("lose_br", 10'd409, 10'd306, 1'b1, 3'd7, 16'd24119, 1'b0);
        bus.win_pulse = 1'b1;
        tick();
        bus.win_pulse = 1'b0;
        check_eq("lose_ign_win", 32'(bus.end_active), 1);
        run_px("lose_keep", 10'd230, 10'd182, 1'b1, 3'd7, 16'd1620, 1'b0);

        // Clear aborts at the next frame boundary without a done pulse.
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_eq("clr_wait_active", 32'(bus.end_active), 1);
        frame_start_pulse();
        check_eq("clr_active", 32'(bus.end_active), 0);
        check_eq("clr_done", 32'(bus.end_done), 0);
        tick();
        check_eq("clr_done_after", 32'(bus.end_done), 0);
        run_px("clr_bg", 10'd230, 10'd173, 1'b1, 3'd0, 16'd8370, 1'b0);

        // Simultaneous requests resolve to lose.
        bus.win_pulse = 1'b1;
        bus.lose_pulse = 1'b1;
        tick();
        bus.win_pulse = 1'b0;
        bus.lose_pulse = 1'b0;
        frame_start_pulse();
        check_eq("both_active", 32'(bus.end_active), 1);
        run_px("both", 10'd230, 10'd173, 1'b1, 3'd7, 16'd0, 1'b0);

        // Asynchronous reset while a lose-screen pixel is in flight.
        bus.pixel_x = 10'd409;
        bus.pixel_y = 10'd306;
        bus.pixel_valid = 1'b1;
        tick();
        bus.pixel_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sel", 32'(bus.selector), 0);
        check_eq("mid_rst_addr", 32'(bus.mem_addr), 0);
        check_eq("mid_rst_px", 32'(bus.px_out), 0);
        check_eq("mid_rst_pv", 32'(bus.px_valid), 0);
        check_eq("mid_rst_active", 32'(bus.end_active), 0);
        tick();
        rst_n = 1'b1;
        tick();
        $display("mid-line reset applied and released");
        run_px("post_rst", 10'd200, 10'd200, 1'b1, 3'd0, 16'd18060, 1'b0);
        run_px("post_rst_idle", 10'd230, 10'd173, 1'b1, 3'd0, 16'd8370, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
